// File: rtl/multicycle_ctrl_gen2_if.sv
// Memory/instruction-register handshake bundle for multicycle_ctrl_gen2.
// The master side is the controller; the slave side is the IR and memory.
interface multicycle_ctrl_gen2_if #(
    parameter int OPCODE_W = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                mem_req;

    modport master (
        input  opcode,
        input  mem_ready,
        output mem_req
    );

    modport slave (
        output opcode,
        output mem_ready,
        input  mem_req
    );
endinterface

// File: rtl/multicycle_ctrl_gen2.sv
// Multicycle control FSM for the 16-bit datapath with a memory req/ready handshake.
// Optional cycle counter is built only when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl_gen2 #(
    parameter int OPCODE_W = 4,
    parameter int ICOUNT_W = 16,
    parameter int CCOUNT_W = 32
) (
    input  logic                 CLK,
    input  logic                 reset,
    multicycle_ctrl_gen2_if.master bus,
    output logic [1:0]           iord,
    output logic [1:0]           aluop,
    output logic [1:0]           regsrc,
    output logic [1:0]           pcsrc,
    output logic [1:0]           alusrca,
    output logic [1:0]           alusrcb,
    output logic                 regw,
    output logic                 memw,
    output logic                 mdrw,
    output logic                 srw,
    output logic                 irw,
    output logic                 pcw,
    output logic                 compcodew,
    output logic                 outputw,
    output logic                 aluoutw,
    output logic                 is_lli,
    output logic                 is_slli,
    output logic                 is_branch,
    output logic                 is_decode,
    output logic                 halted,
    output logic                 illegal,
    output logic [ICOUNT_W-1:0]  num_instr,
    output logic [CCOUNT_W-1:0]  num_cycles
);

    typedef enum logic [4:0] {
        S_RESET  = 5'd0,
        S_FETCH  = 5'd1,
        S_FETCH2 = 5'd2,
        S_DECODE = 5'd3,
        S_ADDR   = 5'd4,
        S_LW1    = 5'd5,
        S_LW2    = 5'd6,
        S_SW     = 5'd7,
        S_LMEM1  = 5'd8,
        S_LMEM2  = 5'd9,
        S_SMEM   = 5'd10,
        S_BMEM1  = 5'd11,
        S_BMEM2  = 5'd12,
        S_ADD    = 5'd13,
        S_SUB    = 5'd14,
        S_WB     = 5'd15,
        S_ADDI   = 5'd16,
        S_ADDI2  = 5'd17,
        S_CMPI   = 5'd18,
        S_CMP    = 5'd19,
        S_PREB   = 5'd20,
        S_B      = 5'd21,
        S_LLI    = 5'd22,
        S_SLLI   = 5'd23,
        S_HALT   = 5'd24,
        S_LI     = 5'd25,
        S_SO     = 5'd26
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic [1:0] iord;
        logic [1:0] aluop;
        logic [1:0] regsrc;
        logic [1:0] pcsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic       regw;
        logic       memw;
        logic       mdrw;
        logic       srw;
        logic       irw;
        logic       pcw;
        logic       compcodew;
        logic       outputw;
        logic       aluoutw;
        logic       is_lli;
        logic       is_slli;
        logic       is_branch;
        logic       is_decode;
        logic       halted;
    } ctrl_t;

    state_t              state;
    state_t              state_nxt;
    ctrl_t               ctl;
    logic [OPCODE_W-1:0] op;
    logic [3:0]          op_lo;
    logic                op_bad;
    logic                illegal_q;
    logic [ICOUNT_W-1:0] num_instr_q;

    assign op     = bus.opcode;
    assign op_lo  = op[3:0];
    assign op_bad = (op >> 4) != '0;

    function automatic state_t next_of(state_t s, logic [3:0] lo, logic bad, logic rdy);
        state_t n;
        n = S_FETCH;
        case (s)
            S_RESET:  n = S_FETCH;
            S_FETCH:  n = rdy ? S_FETCH2 : S_FETCH;
            S_FETCH2: n = S_DECODE;
            S_DECODE: begin
                if (bad) begin
                    n = S_FETCH;
                end else begin
                    case (lo)
                        4'd0:    n = S_LW1;
                        4'd1:    n = S_SW;
                        4'd2, 4'd3, 4'd4, 4'd5, 4'd8: n = S_ADDR;
                        4'd6:    n = S_ADDI;
                        4'd7:    n = S_CMPI;
                        4'd9:    n = S_PREB;
                        4'd10:   n = S_BMEM1;
                        4'd11:   n = S_LLI;
                        4'd12:   n = S_SLLI;
                        4'd13:   n = S_HALT;
                        4'd14:   n = S_LI;
                        default: n = S_SO;
                    endcase
                end
            end
            // The opcode is re-sampled here; anything outside the ADDR group aborts to fetch.
            S_ADDR: begin
                if (bad) begin
                    n = S_FETCH;
                end else begin
                    case (lo)
                        4'd2:    n = S_LMEM1;
                        4'd3:    n = S_SMEM;
                        4'd4:    n = S_ADD;
                        4'd5:    n = S_SUB;
                        4'd8:    n = S_CMP;
                        default: n = S_FETCH;
                    endcase
                end
            end
            S_LW1:    n = rdy ? S_LW2 : S_LW1;
            S_SW:     n = rdy ? S_FETCH : S_SW;
            S_LMEM1:  n = rdy ? S_LMEM2 : S_LMEM1;
            S_SMEM:   n = rdy ? S_FETCH : S_SMEM;
            S_BMEM1:  n = rdy ? S_BMEM2 : S_BMEM1;
            S_ADD:    n = S_WB;
            S_SUB:    n = S_WB;
            S_ADDI:   n = S_ADDI2;
            S_PREB:   n = S_B;
            S_HALT:   n = S_HALT;
            default:  n = S_FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t outputs_of(state_t s);
        ctrl_t c;
        c        = '0;
        c.regsrc = 2'd3;
        case (s)
            S_FETCH: begin
                c.mem_req = 1'b1; c.alusrca = 2'd3; c.alusrcb = 2'd2;
                c.aluop   = 2'd2; c.aluoutw = 1'b1;
            end
            S_FETCH2: begin c.irw = 1'b1; c.pcw = 1'b1; end
            S_DECODE: begin c.compcodew = 1'b1; c.aluoutw = 1'b1; c.is_decode = 1'b1; end
            S_ADDR:   begin c.mdrw = 1'b1; c.iord = 2'd2; end
            S_LW1:    begin c.mem_req = 1'b1; c.mdrw = 1'b1; c.iord = 2'd2; end
            S_SW:     begin c.mem_req = 1'b1; c.memw = 1'b1; c.iord = 2'd2; end
            S_LMEM1:  begin c.mem_req = 1'b1; c.mdrw = 1'b1; c.iord = 2'd3; end
            S_SMEM: begin
                c.mem_req = 1'b1; c.memw = 1'b1; c.mdrw = 1'b1; c.iord = 2'd3;
            end
            S_BMEM1:  begin c.mem_req = 1'b1; c.mdrw = 1'b1; c.iord = 2'd1; end
            S_LW2, S_LMEM2: begin c.regw = 1'b1; c.regsrc = 2'd0; end
            S_ADD, S_SUB: begin
                c.aluop   = (s == S_SUB) ? 2'd3 : 2'd2;
                c.alusrca = 2'd0; c.alusrcb = 2'd1; c.aluoutw = 1'b1;
            end
            S_WB:     begin c.regw = 1'b1; c.regsrc = 2'd1; c.aluoutw = 1'b1; end
            S_ADDI: begin
                c.aluop = 2'd2; c.alusrca = 2'd1; c.alusrcb = 2'd1; c.aluoutw = 1'b1;
            end
            S_ADDI2:  begin c.regw = 1'b1; c.regsrc = 2'd1; end
            S_CMPI, S_CMP: begin
                c.aluop   = 2'd3;
                c.alusrca = (s == S_CMPI) ? 2'd1 : 2'd0;
                c.alusrcb = 2'd1; c.aluoutw = 1'b1; c.srw = 1'b1;
            end
            S_PREB, S_B: c.is_branch = 1'b1;
            S_BMEM2:  begin c.is_branch = 1'b1; c.pcsrc = 2'd2; end
            S_LLI:    begin c.regw = 1'b1; c.is_lli = 1'b1; c.regsrc = 2'd2; end
            S_SLLI:   begin c.regw = 1'b1; c.is_slli = 1'b1; c.regsrc = 2'd2; end
            S_LI:     begin c.regw = 1'b1; c.regsrc = 2'd3; end
            S_SO:     c.outputw = 1'b1;
            S_HALT:   c.halted = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt = next_of(state, op_lo, op_bad, bus.mem_ready);
    end

    // Outputs are registered from the next state so they line up with the state register
    // and still clear asynchronously with reset (mem_req/memw drop mid-wait).
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state       <= S_RESET;
            ctl         <= outputs_of(S_RESET);
            num_instr_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            ctl   <= outputs_of(state_nxt);
            if (state == S_FETCH2) begin
                num_instr_q <= num_instr_q + 1'b1;
            end
            if (state == S_DECODE && op_bad) begin
                illegal_q <= 1'b1;
            end
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CCOUNT_W-1:0] num_cycles_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            num_cycles_q <= '0;
        end else begin
            num_cycles_q <= num_cycles_q + 1'b1;
        end
    end

    assign num_cycles = num_cycles_q;
`else
    assign num_cycles = '0;
`endif

    assign bus.mem_req = ctl.mem_req;
    assign iord        = ctl.iord;
    assign aluop       = ctl.aluop;
    assign regsrc      = ctl.regsrc;
    assign pcsrc       = ctl.pcsrc;
    assign alusrca     = ctl.alusrca;
    assign alusrcb     = ctl.alusrcb;
    assign regw        = ctl.regw;
    assign memw        = ctl.memw;
    assign mdrw        = ctl.mdrw;
    assign srw         = ctl.srw;
    assign irw         = ctl.irw;
    assign pcw         = ctl.pcw;
    assign compcodew   = ctl.compcodew;
    assign outputw     = ctl.outputw;
    assign aluoutw     = ctl.aluoutw;
    assign is_lli      = ctl.is_lli;
    assign is_slli     = ctl.is_slli;
    assign is_branch   = ctl.is_branch;
    assign is_decode   = ctl.is_decode;
    assign halted      = ctl.halted;
    assign illegal     = illegal_q;
    assign num_instr   = num_instr_q;

endmodule

// File: tb/tb_multicycle_ctrl_gen2.sv
// Bench for multicycle_ctrl_gen2: each instruction is expanded into its list of named
// steps with per-step outputs; the list is walked cycle by cycle against the DUT.
module tb_multicycle_ctrl_gen2;

    localparam int OW  = 5;
    localparam int ICW = 4;
    localparam int CCW = 8;

    logic CLK   = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    multicycle_ctrl_gen2_if #(.OPCODE_W(OW)) bus ();

    logic [1:0] iord, aluop, regsrc, pcsrc, alusrca, alusrcb;
    logic regw, memw, mdrw, srw, irw, pcw, compcodew, outputw, aluoutw;
    logic is_lli, is_slli, is_branch, is_decode, halted, illegal;
    logic [ICW-1:0] num_instr;
    logic [CCW-1:0] num_cycles;

    multicycle_ctrl_gen2 #(.OPCODE_W(OW), .ICOUNT_W(ICW), .CCOUNT_W(CCW)) dut (
        .CLK(CLK), .reset(reset), .bus(bus),
        .iord(iord), .aluop(aluop), .regsrc(regsrc), .pcsrc(pcsrc),
        .alusrca(alusrca), .alusrcb(alusrcb),
        .regw(regw), .memw(memw), .mdrw(mdrw), .srw(srw), .irw(irw), .pcw(pcw),
        .compcodew(compcodew), .outputw(outputw), .aluoutw(aluoutw),
        .is_lli(is_lli), .is_slli(is_slli), .is_branch(is_branch), .is_decode(is_decode),
        .halted(halted), .illegal(illegal), .num_instr(num_instr), .num_cycles(num_cycles)
    );

    typedef struct packed {
        logic       mem_req;
        logic [1:0] iord, aluop, regsrc, pcsrc, alusrca, alusrcb;
        logic       regw, memw, mdrw, srw, irw, pcw, compcodew, outputw, aluoutw;
        logic       is_lli, is_slli, is_branch, is_decode, halted;
    } word_t;

    word_t obs;
    assign obs = {bus.mem_req, iord, aluop, regsrc, pcsrc, alusrca, alusrcb,
                  regw, memw, mdrw, srw, irw, pcw, compcodew, outputw, aluoutw,
                  is_lli, is_slli, is_branch, is_decode, halted};

    int    checks = 0;
    int    passes = 0;
    string q[$];
    int    op_cur = 0;
    int    ni = 0, ill = 0, cyc = 0, stay = 0, memw_cnt = 0;
    bit    stopped = 0;

    function automatic word_t expect_of(string st);
        word_t w;
        w = '0;
        w.regsrc = 2'd3;
        case (st)
            "FETCH":  begin w.mem_req = 1; w.alusrca = 3; w.alusrcb = 2; w.aluop = 2; w.aluoutw = 1; end
            "FETCH2": begin w.irw = 1; w.pcw = 1; end
            "DECODE": begin w.compcodew = 1; w.aluoutw = 1; w.is_decode = 1; end
            "ADDR":   begin w.mdrw = 1; w.iord = 2; end
            "LW1":    begin w.mem_req = 1; w.mdrw = 1; w.iord = 2; end
            "SW":     begin w.mem_req = 1; w.memw = 1; w.iord = 2; end
            "LMEM1":  begin w.mem_req = 1; w.mdrw = 1; w.iord = 3; end
            "SMEM":   begin w.mem_req = 1; w.memw = 1; w.mdrw = 1; w.iord = 3; end
            "BMEM1":  begin w.mem_req = 1; w.mdrw = 1; w.iord = 1; end
            "LW2", "LMEM2": begin w.regw = 1; w.regsrc = 0; end
            "ADD":    begin w.aluop = 2; w.alusrca = 0; w.alusrcb = 1; w.aluoutw = 1; end
            "SUB":    begin w.aluop = 3; w.alusrca = 0; w.alusrcb = 1; w.aluoutw = 1; end
            "WB":     begin w.regw = 1; w.regsrc = 1; w.aluoutw = 1; end
            "ADDI":   begin w.aluop = 2; w.alusrca = 1; w.alusrcb = 1; w.aluoutw = 1; end
            "ADDI2":  begin w.regw = 1; w.regsrc = 1; end
            "CMPI":   begin w.aluop = 3; w.alusrca = 1; w.alusrcb = 1; w.aluoutw = 1; w.srw = 1; end
            "CMP":    begin w.aluop = 3; w.alusrca = 0; w.alusrcb = 1; w.aluoutw = 1; w.srw = 1; end
            "PREB", "B": w.is_branch = 1;
            "BMEM2":  begin w.is_branch = 1; w.pcsrc = 2; end
            "LLI":    begin w.regw = 1; w.is_lli = 1; w.regsrc = 2; end
            "SLLI":   begin w.regw = 1; w.is_slli = 1; w.regsrc = 2; end
            "LI":     begin w.regw = 1; w.regsrc = 3; end
            "SO":     w.outputw = 1;
            "HALT":   w.halted = 1;
            default:  ;
        endcase
        return w;
    endfunction

    task automatic build(int op);
        q.push_back("FETCH"); q.push_back("FETCH2"); q.push_back("DECODE");
        case (op)
            0:  begin q.push_back("LW1"); q.push_back("LW2"); end
            1:  q.push_back("SW");
            2:  begin q.push_back("ADDR"); q.push_back("LMEM1"); q.push_back("LMEM2"); end
            3:  begin q.push_back("ADDR"); q.push_back("SMEM"); end
            4:  begin q.push_back("ADDR"); q.push_back("ADD"); q.push_back("WB"); end
            5:  begin q.push_back("ADDR"); q.push_back("SUB"); q.push_back("WB"); end
            6:  begin q.push_back("ADDI"); q.push_back("ADDI2"); end
            7:  q.push_back("CMPI");
            8:  begin q.push_back("ADDR"); q.push_back("CMP"); end
            9:  begin q.push_back("PREB"); q.push_back("B"); end
            10: begin q.push_back("BMEM1"); q.push_back("BMEM2"); end
            11: q.push_back("LLI");
            12: q.push_back("SLLI");
            13: q.push_back("HALT");
            14: q.push_back("LI");
            15: q.push_back("SO");
            default: ;
        endcase
    endtask

    task automatic check(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    endtask

    function automatic int pick();
        int r;
        r = $urandom_range(0, 15);
        if (r == 13) r = 14;
        if ($urandom_range(0, 7) == 0) r = 16 + $urandom_range(0, 15);
        return r;
    endfunction

    // mode 0: random mem_ready, 1: always ready, 2: ready after 3 wait cycles per step
    task automatic run(int n, int mode, int fixed, string stop_at);
        string h;
        word_t w;
        logic  rdy;
        stopped = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (q.size() == 0) begin
                op_cur = (fixed >= 0) ? fixed : pick();
                bus.opcode = op_cur[OW-1:0];
                build(op_cur);
                stay = 0;
            end
            h = q[0];
            w = expect_of(h);
            check({"ctl@", h}, 32'(obs), 32'(w));
            check("num_instr", 32'(num_instr), ni % 16);
            check("illegal", 32'(illegal), ill);
`ifdef CTRL_PERF_CNT_EN
            check("num_cycles", 32'(num_cycles), cyc % 256);
`else
            check("num_cycles", 32'(num_cycles), 0);
`endif
            if (obs.memw) memw_cnt++;
            if (h == stop_at && stay >= 1) begin
                stopped = 1;
                return;
            end
            case (mode)
                0:       rdy = 1'($urandom_range(0, 1));
                1:       rdy = 1'b1;
                default: rdy = (stay >= 3);
            endcase
            bus.mem_ready = rdy;
            if (w.halted || (w.mem_req && !rdy)) begin
                stay++;
            end else begin
                if (h == "FETCH2") ni++;
                if (h == "DECODE" && op_cur > 15) ill = 1;
                void'(q.pop_front());
                stay = 0;
            end
            cyc++;
        end
    endtask

    task automatic pulse_reset();
        bus.mem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_ctl", 32'(obs), 32'(expect_of("RESET")));
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_memw", 32'(memw), 0);
        check("rst_num_instr", 32'(num_instr), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_num_cycles", 32'(num_cycles), 0);
        @(posedge CLK);
        #1 reset = 1'b0;
        q.delete();
        q.push_back("RESET");
        ni = 0; ill = 0; cyc = 0; stay = 0; memw_cnt = 0;
    endtask

    initial begin
        bus.opcode    = '0;
        bus.mem_ready = 1'b0;
        pulse_reset();

        // ADD with zero wait states
        run(16, 1, 4, "");

        // SW with three wait cycles: exactly four memw cycles
        pulse_reset();
        run(14, 2, 1, "");
        check("sw_memw_cycles", memw_cnt, 4);

        // reset in the middle of an LW1 wait
        pulse_reset();
        run(40, 2, 0, "LW1");
        check("reached_lw1", 32'(stopped), 1);
        check("lw1_mem_req", 32'(bus.mem_req), 1);
        pulse_reset();

        // illegal opcode is sticky
        run(12, 1, 20, "");
        check("illegal_sticky", 32'(illegal), 1);
        run(60, 0, -1, "");

        // HALT absorbs, counters behave
        pulse_reset();
        run(40, 0, 13, "");
        check("halted", 32'(halted), 1);
        check("halt_num_instr", 32'(num_instr), 1);
        pulse_reset();

        // num_instr wraps after 16 LI instructions
        run(65, 1, 14, "");
        check("icount_wrap", 32'(num_instr), 0);

        // random instruction mix
        pulse_reset();
        run(600, 0, -1, "");
        run(200, 1, -1, "");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
